// File: rtl/cmd_asm_pkg.sv
// Shared types and constants for the SUMP/OLS command assembler.
package cmd_asm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } cmd_asm_state_t;

  localparam int LONG_CMD_BIT = 7;
  localparam int ARG_BYTES    = 4;
  localparam int IDX_W        = $clog2(ARG_BYTES);

endpackage

// File: rtl/cmd_asm_tmo.sv
// Inter-byte idle counter; expired pulses on the idle cycle that reaches TMO_CYC.
module cmd_asm_tmo #(
  parameter int TMO_CYC = 100_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] LIM = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] cnt;

  // A byte in the same cycle (clr) always beats expiry.
  assign expired = en && !clr && (cnt == LIM);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr || !en || expired) cnt <= '0;
    else                                cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cmd_asm.sv
// Assembles UART bytes into SUMP/OLS commands (short: 1 byte, long: opcode + 4 arg bytes LSB first).
// Inter-byte timeout is built only when CMD_ASM_TIMEOUT_EN is defined.
module cmd_asm
  import cmd_asm_pkg::*;
#(
  parameter int TMO_CYC = 100_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stb_i,
  input  logic [7:0]  dat_i,
  output logic        stb_o,
  output logic [7:0]  opc_o,
  output logic [31:0] cmd_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  cmd_asm_state_t   state, state_d;
  logic [IDX_W-1:0] idx;
  logic [7:0]       opc_q;
  logic [31:0]      arg_q, arg_nxt;
  logic             start, take_arg, last_arg, emit_short, emit_long, tmo_exp;

  assign last_arg = (idx == IDX_W'(ARG_BYTES - 1));

`ifdef CMD_ASM_TIMEOUT_EN
  cmd_asm_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (stb_i),
    .en      (state == COLLECT),
    .expired (tmo_exp)
  );
`else
  logic [TMO_W-1:0] unused_tmo_w;
  assign unused_tmo_w = '0;
  assign tmo_exp      = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    start      = 1'b0;
    take_arg   = 1'b0;
    emit_short = 1'b0;
    emit_long  = 1'b0;
    // Argument including the byte arriving now, so the final byte lands in cmd_o directly.
    arg_nxt    = arg_q;
    arg_nxt[{idx, 3'b000} +: 8] = dat_i;
    case (state)
      IDLE: begin
        if (stb_i) begin
          if (dat_i[LONG_CMD_BIT]) begin
            start   = 1'b1;
            state_d = COLLECT;
          end else begin
            emit_short = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (stb_i) begin
          take_arg = 1'b1;
          if (last_arg) begin
            emit_long = 1'b1;
            state_d   = IDLE;
          end
        end else if (tmo_exp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      idx    <= '0;
      opc_q  <= '0;
      arg_q  <= '0;
      stb_o  <= 1'b0;
      opc_o  <= '0;
      cmd_o  <= '0;
      busy_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_d;
      busy_o <= (state_d == COLLECT);
      stb_o  <= emit_short | emit_long;
      err_o  <= tmo_exp;
      if (start) begin
        opc_q <= dat_i;
        idx   <= '0;
        arg_q <= '0;
      end
      if (take_arg) begin
        arg_q <= arg_nxt;
        idx   <= last_arg ? '0 : idx + 1'b1;
      end
      if (tmo_exp) idx <= '0;
      if (emit_short) begin
        opc_o <= dat_i;
        cmd_o <= '0;
      end
      if (emit_long) begin
        opc_o <= opc_q;
        cmd_o <= arg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cmd_asm.sv
// Self-checking bench for cmd_asm: directed scenarios plus random byte streams vs a queue-based model.
module tb_cmd_asm;

  localparam int TMO = 10;
`ifdef CMD_ASM_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, stb_i;
  logic [7:0]  dat_i;
  logic        stb_o, busy_o, err_o;
  logic [7:0]  opc_o;
  logic [31:0] cmd_o;

  int checks = 0;
  int errors = 0;

  cmd_asm #(.TMO_CYC(TMO)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .stb_i  (stb_i),
    .dat_i  (dat_i),
    .stb_o  (stb_o),
    .opc_o  (opc_o),
    .cmd_o  (cmd_o),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pending opcode plus a queue of collected argument bytes.
  bit          m_pend;
  logic [7:0]  m_op;
  logic [7:0]  m_bytes[$];
  int          m_idle;
  logic        m_stb, m_err, m_busy;
  logic [7:0]  m_opc;
  logic [31:0] m_cmd;

  function automatic void model_step(input bit r, input bit s, input logic [7:0] d);
    m_stb = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_pend = 1'b0; m_bytes.delete(); m_idle = 0; m_opc = '0; m_cmd = '0;
    end else if (m_pend) begin
      if (s) begin
        m_bytes.push_back(d);
        m_idle = 0;
        if (m_bytes.size() == 4) begin
          m_stb = 1'b1; m_opc = m_op; m_cmd = '0;
          foreach (m_bytes[i]) m_cmd += 32'(m_bytes[i]) << (8 * i);
          m_pend = 1'b0;
        end
      end else begin
        m_idle++;
        if (TMO_ON && m_idle == TMO) begin
          m_err = 1'b1; m_pend = 1'b0;
        end
      end
    end else if (s) begin
      if (d >= 8'h80) begin
        m_pend = 1'b1; m_op = d; m_bytes.delete(); m_idle = 0;
      end else begin
        m_stb = 1'b1; m_opc = d; m_cmd = '0;
      end
    end
    m_busy = m_pend;
  endfunction

  // Drive one cycle; outputs are sampled 1 time unit after the edge.
  task automatic drive(input bit r, input bit s, input logic [7:0] d);
    @(negedge clk_i);
    rst_i = r; stb_i = s; dat_i = d;
    @(posedge clk_i);
    model_step(r, s, d);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h85);
    checks++;
    if ({stb_o, busy_o, err_o, opc_o, cmd_o} !== 43'h0) begin
      errors++;
      $display("FAIL reset_state: got stb=%b busy=%b err=%b opc=%h cmd=%h, required all zero",
               stb_o, busy_o, err_o, opc_o, cmd_o);
    end
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if ({stb_o, busy_o, err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got stb/busy/err=%b required 000", {stb_o, busy_o, err_o});
    end
  endtask

  task automatic test_short();
    drive(1'b0, 1'b1, 8'h01);
    checks++;
    if ({stb_o, busy_o, opc_o, cmd_o} !== {1'b1, 1'b0, 8'h01, 32'h0}) begin
      errors++;
      $display("FAIL short_cmd: got stb=%b busy=%b opc=%h cmd=%h required 1 0 01 00000000",
               stb_o, busy_o, opc_o, cmd_o);
    end
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (stb_o !== 1'b0) begin
      errors++;
      $display("FAIL short_pulse: stb_o=%b one cycle later, required 0", stb_o);
    end
  endtask

  task automatic test_long();
    logic [7:0] seq [5];
    seq = '{8'hC0, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, seq[i]);
      checks++;
      if ({stb_o, busy_o} !== 2'b01) begin
        errors++;
        $display("FAIL long_collect byte %0d: got stb/busy=%b required 01", i, {stb_o, busy_o});
      end
    end
    drive(1'b0, 1'b1, seq[4]);
    checks++;
    if ({stb_o, busy_o, opc_o, cmd_o} !== {1'b1, 1'b0, 8'hC0, 32'h44332211}) begin
      errors++;
      $display("FAIL long_cmd: got stb=%b busy=%b opc=%h cmd=%h required 1 0 c0 44332211",
               stb_o, busy_o, opc_o, cmd_o);
    end
  endtask

  task automatic test_timeout();
    int err_cnt = 0;
    int err_at  = -1;
    int stb_cnt = 0;
    drive(1'b0, 1'b1, 8'h80);
    drive(1'b0, 1'b1, 8'hAA);
    for (int k = 1; k <= TMO + 3; k++) begin
      drive(1'b0, 1'b0, 8'h00);
      if (err_o === 1'b1) begin err_cnt++; err_at = k; end
      if (stb_o === 1'b1) stb_cnt++;
    end
    checks++;
    if (err_cnt !== int'(TMO_ON)) begin
      errors++;
      $display("FAIL tmo_err_count: got %0d pulses required %0d", err_cnt, int'(TMO_ON));
    end
    checks++;
    if (err_at !== (TMO_ON ? TMO : -1)) begin
      errors++;
      $display("FAIL tmo_err_cycle: got %0d required %0d", err_at, TMO_ON ? TMO : -1);
    end
    checks++;
    if (stb_cnt !== 0 || busy_o !== !TMO_ON) begin
      errors++;
      $display("FAIL tmo_after: got stb_cnt=%0d busy=%b required 0 %b", stb_cnt, busy_o, !TMO_ON);
    end
    // With the timeout this is a fresh short command; without it the byte continues the argument.
    drive(1'b0, 1'b1, 8'h02);
    checks++;
    if (stb_o !== m_stb || busy_o !== m_busy || (m_stb && opc_o !== m_opc)) begin
      errors++;
      $display("FAIL tmo_next: got stb=%b busy=%b opc=%h required %b %b %h",
               stb_o, busy_o, opc_o, m_stb, m_busy, m_opc);
    end
    drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_race();
    logic [7:0] seq [5];
    int err_cnt = 0;
    seq = '{8'h90, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, seq[0]);
    for (int i = 1; i < 5; i++) begin
      for (int g = 0; g < TMO - 1; g++) begin
        drive(1'b0, 1'b0, 8'h00);
        if (err_o === 1'b1) err_cnt++;
      end
      drive(1'b0, 1'b1, seq[i]);
      if (err_o === 1'b1) err_cnt++;
    end
    checks++;
    if ({stb_o, opc_o, cmd_o} !== {1'b1, 8'h90, 32'hEFBEADDE}) begin
      errors++;
      $display("FAIL race_cmd: got stb=%b opc=%h cmd=%h required 1 90 efbeadde", stb_o, opc_o, cmd_o);
    end
    drive(1'b0, 1'b0, 8'h00);
    if (err_o === 1'b1) err_cnt++;
    checks++;
    if (err_cnt !== 0) begin
      errors++;
      $display("FAIL race_err: got %0d err pulses required 0", err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int stb_cnt = 0;
    drive(1'b0, 1'b1, 8'h81);
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h02);
    drive(1'b1, 1'b0, 8'h00);
    checks++;
    if ({stb_o, busy_o, err_o} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_state: got stb/busy/err=%b required 000", {stb_o, busy_o, err_o});
    end
    drive(1'b0, 1'b1, 8'h03);
    checks++;
    if ({stb_o, opc_o, cmd_o} !== {1'b1, 8'h03, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_03: got stb=%b opc=%h cmd=%h required 1 03 0", stb_o, opc_o, cmd_o);
    end
    drive(1'b0, 1'b1, 8'h04);
    checks++;
    if ({stb_o, opc_o, cmd_o} !== {1'b1, 8'h04, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_04: got stb=%b opc=%h cmd=%h required 1 04 0", stb_o, opc_o, cmd_o);
    end
    for (int k = 0; k < TMO + 2; k++) begin
      drive(1'b0, 1'b0, 8'h00);
      if (stb_o === 1'b1 || err_o === 1'b1) stb_cnt++;
    end
    checks++;
    if (stb_cnt !== 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d stb/err pulses after reset required 0", stb_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      checks++;
      if ({stb_o, busy_o, opc_o, cmd_o} !== {1'b1, 1'b0, 8'h00, 32'h0}) begin
        errors++;
        $display("FAIL b2b %0d: got stb=%b busy=%b opc=%h cmd=%h required 1 0 00 0",
                 i, stb_o, busy_o, opc_o, cmd_o);
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (stb_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: stb_o=%b required 0", stb_o);
    end
  endtask

  task automatic test_random();
    int r, gap;
    bit rr, s;
    logic [7:0] d;
    for (int n = 0; n < 400; n++) begin
      r   = $urandom_range(0, 99);
      rr  = (r == 0);
      s   = !rr && (r < 60);
      d   = 8'($urandom);
      d[7] = ($urandom_range(0, 2) == 0);
      gap = (r >= 60 && r < 66) ? $urandom_range(TMO - 2, TMO + 1) : 0;
      for (int g = 0; g <= gap; g++) begin
        drive(g == 0 ? rr : 1'b0, g == 0 ? s : 1'b0, d);
        checks++;
        if ({stb_o, busy_o, err_o} !== {m_stb, m_busy, m_err}) begin
          errors++;
          $display("FAIL rand_ctrl n=%0d: got stb/busy/err=%b required %b",
                   n, {stb_o, busy_o, err_o}, {m_stb, m_busy, m_err});
        end
        if (m_stb) begin
          checks++;
          if ({opc_o, cmd_o} !== {m_opc, m_cmd}) begin
            errors++;
            $display("FAIL rand_data n=%0d: got opc=%h cmd=%h required %h %h",
                     n, opc_o, cmd_o, m_opc, m_cmd);
          end
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    stb_i = 1'b0;
    dat_i = 8'h00;
    test_reset();
    test_short();
    test_long();
    test_timeout();
    test_race();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_asm.md
Name: cmd_asm

Overview:
- Command assembler between the UART receive byte stream and the instruction decoder.
- Collects SUMP/OLS command bytes:
  - short command: 1 opcode byte, MSB=0.
  - long command: opcode byte with MSB=1, then 4 argument bytes, LSB first.
- Emits one single-cycle strobe with opcode and 32-bit argument, in the form the decoder consumes.
- Discards partial long commands on inter-byte timeout.

Parameters:
- TMO_CYC, 100_000, idle clock cycles allowed between bytes of a long command before it is discarded (>=2).
- TMO_W, $clog2(TMO_CYC+1), timeout counter width (derived, not overridden).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- stb_i  in  1  received byte valid, single-cycle pulse
- dat_i  in  8  received byte
- stb_o  out  1  assembled command valid, single-cycle pulse
- opc_o  out  8  opcode of assembled command
- cmd_o  out  32  argument; {b4,b3,b2,b1} for long commands, 32'h0 for short commands
- busy_o  out  1  high while in COLLECT
- err_o  out  1  single-cycle pulse when a partial command is discarded by timeout

Behaviour:
- Reset: state=IDLE, idx=0, timeout counter=0, stb_o=0, opc_o=8'h00, cmd_o=32'h0, busy_o=0, err_o=0. rst_i is checked before every other event.
- States: IDLE, COLLECT.
- IDLE, stb_i with dat_i[7]=0:
  - Next cycle: stb_o=1, opc_o=dat_i, cmd_o=0.
  - State stays IDLE. Latency 1 cycle.
- IDLE, stb_i with dat_i[7]=1:
  - opc register <= dat_i, idx <= 0, argument register <= 0, counter <= 0.
  - Go to COLLECT. No stb_o.
- COLLECT, stb_i:
  - arg[8*idx +: 8] <= dat_i; counter <= 0.
  - If idx==3: next cycle stb_o=1, opc_o=opc, cmd_o=assembled argument; go to IDLE.
  - Otherwise idx <= idx+1.
- COLLECT, no stb_i: counter increments.
- COLLECT, counter reaches TMO_CYC-1 with no stb_i:
  - Next cycle err_o=1, state=IDLE, idx=0. No stb_o.
- Timeout and byte in the same cycle: the byte wins. It is accepted, the counter clears, no err_o.
- Back-to-back: a byte arriving in the cycle stb_o is high is accepted normally from IDLE. Full throughput is one byte per cycle.
- opc_o/cmd_o hold their last value between strobes and are only guaranteed valid while stb_o=1.
- busy_o = (state==COLLECT), registered.
- Reset mid-command: partial bytes are dropped. No stb_o, no err_o after reset deassertion.
- SUMP reset sequence (5x 8'h00) yields five short-command strobes. The decoder handles soft reset; the assembler does no special-casing.
- No backpressure. The downstream decoder accepts every stb_o.

Optional Feature:
- Macro CMD_ASM_TIMEOUT_EN.
- Defined: timeout counter, TMO_CYC and err_o behave as described above.
- Not defined:
  - No counter is instantiated.
  - err_o is tied 0.
  - COLLECT waits indefinitely for remaining bytes; only rst_i aborts it.
  - TMO_CYC is ignored.

Decomposition:
- Shared package cmd_asm_pkg:
  - state enum cmd_asm_state_t {IDLE, COLLECT}.
  - constant LONG_CMD_BIT = 7.
  - constant ARG_BYTES = 4.
- One natural sub-module: cmd_asm_tmo.
  - Inputs: clr, en.
  - Output: expired pulse.
  - Only instantiated under CMD_ASM_TIMEOUT_EN.

Test Plan:
- Short command: stb_i with dat_i=8'h01 in IDLE -> next cycle stb_o=1, opc_o=8'h01, cmd_o=32'h0, busy_o stays 0.
- Long command: bytes 8'hC0,8'h11,8'h22,8'h33,8'h44 on consecutive cycles -> busy_o high from the cycle after 8'hC0; the cycle after 8'h44 gives stb_o=1, opc_o=8'hC0, cmd_o=32'h44332211, busy_o=0.
- Timeout (macro on, TMO_CYC=10): 8'h80, 8'hAA, then no stb_i -> err_o pulses exactly once, 10 cycles after 8'hAA; no stb_o. A following 8'h02 gives a short strobe with opc_o=8'h02.
- Boundary race: long command with the next byte arriving on the exact cycle the counter reaches TMO_CYC-1 -> no err_o; the command completes with the correct cmd_o.
- Reset mid-command: 8'h81,8'h01,8'h02, then rst_i for 1 cycle, then 8'h03,8'h04 -> no stb_o for the 8'h81 command. After reset, 8'h03 and 8'h04 each produce a short strobe.
- Back-to-back: five 8'h00 bytes on consecutive cycles -> five consecutive stb_o pulses, each with opc_o=8'h00 and cmd_o=0.
